mips_bus_memory: RTL and testbench

Avalon memory-mapped slave that sits directly downstream of the CPU's bus master port and serves both instruction fetches and data loads/stores from one word-addressed RAM window. It inserts a configurable number of wait states through `waitrequest`, applies `byteenable` on writes and returns registered read data the cycle after a read completes. This matches the CPU's FETCH→DECODE and EXEC1→EXEC2 sampling. It is the memory model used by the CPU testbenches and is synthesisable as a block-RAM wrapper.

---
 rtl/mips_bus_memory.sv | 130 +++++++++++++
 tb/tb_mips_bus_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_memory.sv
// mips_bus_memory: Avalon-MM slave serving CPU fetches and loads/stores from
// one word-addressed RAM window. Inserts wait states via waitrequest, applies
// byteenable on writes, returns registered read data after completion and
// raises a sticky bus_error on out-of-window or read+write transfers.
//
// Optional feature: define MIPS_MEM_RANDOM_WAIT_EN to draw each transfer's
// wait count from an 8-bit LFSR (0..WAIT_CYCLES) instead of a fixed count.

module mips_bus_memory #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS) << 2;

    // Window storage; contents start at zero.
    logic [31:0] mem_q [MEM_WORDS] = '{default: '0};

    logic          req;
    logic [31:0]   offset;
    logic          in_win;
    logic [AW-1:0] word_idx;
    logic          complete;
    logic [3:0]    target;

    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          bus_error_q, bus_error_d;

    // Byte-lane bits and the high offset bits only matter through in_win.
    logic          unused_offset_bits;
    assign unused_offset_bits = ^{offset[1:0], offset[31:AW+2]};

    // Address decode, completion detect and the only combinational output.
    always_comb begin
        req         = read | write;
        offset      = address - BASE_ADDR;
        in_win      = offset < WIN_BYTES;
        word_idx    = offset[AW+1:2];
        complete    = req && (cnt_q == target);
        waitrequest = req && (cnt_q != target);
    end

`ifdef MIPS_MEM_RANDOM_WAIT_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] target_q, target_d;
    logic [3:0] fresh_target;

    // Pick a new wait count at the start of each transfer and hold it until
    // that transfer completes or is dropped; the LFSR steps per completion.
    always_comb begin
        fresh_target = 4'(lfsr_q % 8'(WAIT_CYCLES + 1));
        target       = (cnt_q == 4'd0) ? fresh_target : target_q;
        target_d     = target_q;
        if (req && cnt_q == 4'd0) target_d = fresh_target;
        lfsr_d = lfsr_q;
        if (complete) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR and latched target registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= 8'hA5;
            target_q <= 4'd0;
        end else begin
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
        end
    end
`else
    localparam logic [3:0] TARGET = 4'(WAIT_CYCLES);
    assign target = TARGET;
`endif

    // Next-state for wait counter, read data and sticky error.
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d       = 4'd0;
        readdata_d  = readdata_q;
        bus_error_d = bus_error_q;
        if (req && !complete) cnt_d = cnt_q + 4'd1;
        if (complete && read && !write) readdata_d = in_win ? mem_q[word_idx] : 32'h0;
        if (complete && (!in_win || (read && write))) bus_error_d = 1'b1;
    end

    // Control and output registers with synchronous reset.
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 4'd0;
            readdata_q  <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            readdata_q  <= readdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Lane-masked write on an in-window completion; reset cancels it.
    // NOTE: the RAM array has no reset so it maps onto block RAM and keeps
    // its contents across a CPU reset.
    always_ff @(posedge clk) begin
        if (!reset && complete && write && in_win) begin
            for (int n = 0; n < 4; n++) begin
                if (byteenable[n]) mem_q[word_idx][8*n +: 8] <= writedata[8*n +: 8];
            end
        end
    end

    assign readdata  = readdata_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Self-checking bench for mips_bus_memory: directed scenarios plus randomized
// transfers compared against a transaction-level model of the RAM window.

module tb_mips_bus_memory;

    localparam int          WAIT  = 2;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          WORDS = 1024;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state.
    logic [31:0] model_mem [int];
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          tb_lfsr;
    int          wait_hist [16];

    mips_bus_memory #(
        .MEM_WORDS  (WORDS),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(WAIT),
        .INIT_FILE  ("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .read       (read),
        .write      (write),
        .byteenable (byteenable),
        .writedata  (writedata),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .bus_error  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_get(input int idx);
        return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    endfunction

    function automatic int exp_waits();
`ifdef MIPS_MEM_RANDOM_WAIT_EN
        return tb_lfsr % (WAIT + 1);
`else
        return WAIT;
`endif
    endfunction

    task automatic model_reset();
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        tb_lfsr   = 8'hA5;
    endtask

    // Effect of one completed transfer, straight from the bus rules.
    task automatic model_xfer(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] data);
        logic [31:0] off;
        logic [31:0] w;
        bit          inw;
        int          idx;
        int          fb;
        off = addr - BASE;
        inw = off < WORDS * 4;
        idx = int'(off >> 2);
        if (!inw || (rd && wr)) exp_err = 1'b1;
        if (rd && !wr) exp_rdata = inw ? mem_get(idx) : 32'h0;
        if (wr && inw) begin
            w = mem_get(idx);
            for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = data[8*n +: 8];
            model_mem[idx] = w;
        end
        fb      = ((tb_lfsr >> 7) ^ (tb_lfsr >> 5) ^ (tb_lfsr >> 4) ^ (tb_lfsr >> 3)) & 1;
        tb_lfsr = ((tb_lfsr << 1) | fb) & 8'hFF;
    endtask

    // Run one transfer from posedge+1 to posedge+1 after its completion edge.
    task automatic xfer(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
        int waits;
        int exp_w;
        bit done;
        waits = 0;
        done  = 1'b0;
        exp_w = exp_waits();
        read = rd; write = wr; address = addr; byteenable = be; writedata = data;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (waitrequest === 1'b0) done = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (done) begin
            @(posedge clk); #1;
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        read = 1'b0; write = 1'b0;
        model_xfer(rd, wr, addr, be, data);
        if (waits < 16) wait_hist[waits]++;
        check({tag, " waits"}, 32'(waits), 32'(exp_w));
        check({tag, " readdata"}, readdata, exp_rdata);
        check({tag, " bus_error"}, 32'(bus_error), 32'(exp_err));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          rd;
        bit          wr;
        int          sel;

        reset = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        @(posedge clk); #1;
        do_reset();
        #1;
        check("reset readdata", readdata, 32'h0);
        check("reset bus_error", 32'(bus_error), 32'd0);
        check("idle waitrequest", 32'(waitrequest), 32'd0);

        // Reset vector: load word 0, then fetch it with the full wait count.
        xfer("init word0", 1'b0, 1'b1, BASE, 4'hF, 32'h24020005);
        xfer("fetch word0", 1'b1, 1'b0, BASE, 4'h0, 32'h0);

        // Byte-lane merge.
        xfer("wr full", 1'b0, 1'b1, BASE + 32'h10, 4'hF, 32'hDEADBEEF);
        xfer("wr lanes", 1'b0, 1'b1, BASE + 32'h10, 4'b0101, 32'h11223344);
        xfer("rd merged", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        check("merged value", readdata, 32'hDE22BE44);

        // Zero byteenable writes nothing and raises no error.
        xfer("wr be0", 1'b0, 1'b1, BASE + 32'h10, 4'h0, 32'hFFFFFFFF);
        xfer("rd after be0", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);

`ifndef MIPS_MEM_RANDOM_WAIT_EN
        // Dropped read aborts; the following write needs a full wait count.
        read = 1'b1; address = BASE + 32'h20;
        #1;
        check("abort wait1", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        check("abort readdata", readdata, exp_rdata);
        xfer("wr after abort", 1'b0, 1'b1, BASE + 32'h20, 4'hF, 32'hA5A5A5A5);
        xfer("rd after abort", 1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);

        // Reset during the second wait cycle cancels the write.
        write = 1'b1; address = BASE + 32'h10; byteenable = 4'hF; writedata = 32'h12345678;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; write = 1'b0;
        model_reset();
        #1;
        check("rst-abort readdata", readdata, 32'h0);
        check("rst-abort waitreq", 32'(waitrequest), 32'd0);
        xfer("rd after rst-abort", 1'b1, 1'b0, BASE + 32'h10, 4'h0, 32'h0);
        check("old word kept", readdata, 32'hDE22BE44);
`endif

        // Out-of-window accesses and the sticky error.
        xfer("rd outside", 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        xfer("wr outside", 1'b0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        xfer("rd word0 after", 1'b1, 1'b0, BASE, 4'h0, 32'h0);
        xfer("rd above window", 1'b1, 1'b0, BASE + WORDS * 4, 4'h0, 32'h0);
        do_reset();
        #1;
        check("error cleared", 32'(bus_error), 32'd0);

        // Simultaneous read and write: write lands, readdata holds.
        xfer("rd last word", 1'b1, 1'b0, BASE + (WORDS - 1) * 4, 4'h0, 32'h0);
        xfer("rd+wr", 1'b1, 1'b1, BASE + 32'h30, 4'hF, 32'h0BADC0DE);
        xfer("rd rd+wr word", 1'b1, 1'b0, BASE + 32'h30, 4'h0, 32'h0);
        do_reset();

        // Randomized traffic over a small set of words plus stray addresses.
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 19);
            rd  = (sel < 10) || (sel == 19);
            wr  = (sel >= 10);
            a   = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if (sel == 18) a = $urandom;
            be  = 4'($urandom);
            d   = $urandom;
            xfer("rand", rd, wr, a, be, d);
            if (i == 100) do_reset();
        end

`ifdef MIPS_MEM_RANDOM_WAIT_EN
        for (int w = 0; w <= WAIT; w++) check("wait value seen", 32'(wait_hist[w] > 0), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
